// File: rtl/an_barrett_decoder_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : an_barrett_pkg
// Brief   : Derived widths, Barrett constant and result record for the
//           AN-code decoder.
// Revision: 1.0 - initial release
// ============================================================================
package an_barrett_pkg;

    // Result fields are sized for the widest supported configuration; the
    // decoder zero-extends into them and only drives out the low QW/RW bits.
    localparam int AN_QW_MAX = 32;
    localparam int AN_RW_MAX = 32;

    typedef struct packed {
        logic [AN_QW_MAX-1:0] q;
        logic [AN_RW_MAX-1:0] r;
        logic                 err;
    } an_res_t;

    function automatic int an_calc_rw(input int a);
        return $clog2(a);
    endfunction

    function automatic int an_calc_qw(input int w, input int a);
        return $clog2(((longint'(1) << w) - 1) / longint'(a) + 1);
    endfunction

    function automatic int an_calc_k(input int w, input int a);
        return w + an_calc_rw(a);
    endfunction

    function automatic longint an_calc_m(input int w, input int a);
        return (longint'(1) << an_calc_k(w, a)) / longint'(a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/an_barrett_decoder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : an_barrett_decoder_pipe_if
// Brief   : Codeword-in / result-out valid-ready streams of the decoder.
// Revision: 1.0 - initial release
// ============================================================================
interface an_barrett_decoder_pipe_if #(
    parameter int W = 6,
    parameter int A = 13
);
    localparam int RW = an_barrett_pkg::an_calc_rw(A);
    localparam int QW = an_barrett_pkg::an_calc_qw(W, A);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_word;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] out_q;
    logic [RW-1:0] out_r;
    logic          out_err;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_q, out_r, out_err
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_q, out_r, out_err
    );

endinterface
`default_nettype wire

// File: rtl/an_barrett_decoder_pipe_corr.sv
`default_nettype none
// ============================================================================
// Module  : an_barrett_corr
// Brief   : Single-step Barrett correction: (q_est, r_est) -> (q, r, err).
// Revision: 1.0 - initial release
// ============================================================================
module an_barrett_corr #(
    parameter int A  = 13,
    parameter int QW = 3,
    parameter int RW = 4
) (
    input  logic [QW-1:0] q_est_i,
    input  logic [RW:0]   r_est_i,
    output logic [QW-1:0] q_o,
    output logic [RW-1:0] r_o,
    output logic          err_o
);
    localparam logic [RW:0] c_A = (RW+1)'(A);

    logic          w_over;
    logic [RW:0]   w_r_sub;

    // r_est < 2A always holds, so one subtraction lands in [0, A).
    always_comb begin
        w_over  = (r_est_i >= c_A);
        w_r_sub = r_est_i - c_A;
        q_o     = w_over ? (q_est_i + QW'(1)) : q_est_i;
        r_o     = RW'(w_over ? w_r_sub : r_est_i);
    end

    assign err_o = |r_o;

endmodule
`default_nettype wire

// File: rtl/an_barrett_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : an_barrett_decoder_pipe
// Brief   : Three-stage Barrett AN-code decoder with stream handshake and a
//           saturating error counter.
// Revision: 1.0 - initial release
// ============================================================================
module an_barrett_decoder_pipe
    import an_barrett_pkg::*;
#(
    parameter int W     = 6,
    parameter int A     = 13,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    an_barrett_decoder_pipe_if.slave bus,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      err_cnt
);
    localparam int RW = an_calc_rw(A);
    localparam int QW = an_calc_qw(W, A);
    localparam int K  = an_calc_k(W, A);
    localparam int PW = W + K;

    localparam logic [K-1:0]     c_M       = K'(an_calc_m(W, A));
    localparam logic [RW:0]      c_A       = (RW+1)'(A);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             w_en;
    logic             w_xfer_err;

    logic             s1_v_q, s2_v_q, s3_v_q;
    logic [W-1:0]     s1_x_q;
    logic [PW-1:0]    s1_p_q, s1_p_d;
    logic [QW-1:0]    s2_qe_q, s2_qe_d;
    logic [RW:0]      s2_re_q, s2_re_d;
    logic [RW:0]      w_qa;
    an_res_t          res_q, res_d;
    logic [CNT_W-1:0] err_cnt_q;

    logic [QW-1:0]    w_q;
    logic [RW-1:0]    w_r;
    logic             w_err;
    logic             w_unused;

    // A single enable stalls every stage together, so bubbles stay in place.
    assign w_en          = bus.out_ready | ~s3_v_q;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = s3_v_q;
    assign bus.out_q     = res_q.q[QW-1:0];
    assign bus.out_r     = res_q.r[RW-1:0];
    assign bus.out_err   = res_q.err;
    assign err_cnt       = err_cnt_q;

    // S1: P = x * M as a shift-add over the set bits of the constant.
    always_comb begin
        s1_p_d = '0;
        for (int i = 0; i < K; i++) begin
            if (c_M[i]) begin
                s1_p_d = s1_p_d + (PW'(bus.in_word) << i);
            end
        end
    end

    // S2: only the low RW+1 bits of x - q_est*A matter since r_est < 2A.
    always_comb begin
        s2_qe_d = s1_p_q[K +: QW];
        w_qa    = '0;
        for (int i = 0; i <= RW; i++) begin
            if (c_A[i]) begin
                w_qa = w_qa + ((RW+1)'(s2_qe_d) << i);
            end
        end
        s2_re_d = (RW+1)'(s1_x_q) - w_qa;
    end

    an_barrett_corr #(
        .A  (A),
        .QW (QW),
        .RW (RW)
    ) u_corr (
        .q_est_i (s2_qe_q),
        .r_est_i (s2_re_q),
        .q_o     (w_q),
        .r_o     (w_r),
        .err_o   (w_err)
    );

    always_comb begin
        res_d     = '0;
        res_d.q   = AN_QW_MAX'(w_q);
        res_d.r   = AN_RW_MAX'(w_r);
        res_d.err = w_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            s3_v_q  <= 1'b0;
            s1_x_q  <= '0;
            s1_p_q  <= '0;
            s2_qe_q <= '0;
            s2_re_q <= '0;
            res_q   <= '0;
        end else if (w_en) begin
            s1_v_q <= bus.in_valid;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            if (bus.in_valid) begin
                s1_x_q <= bus.in_word;
                s1_p_q <= s1_p_d;
            end
            if (s1_v_q) begin
                s2_qe_q <= s2_qe_d;
                s2_re_q <= s2_re_d;
            end
            if (s2_v_q) begin
                res_q <= res_d;
            end
        end
    end

    assign w_xfer_err = s3_v_q & bus.out_ready & res_q.err;

    // A clear coinciding with a counted transfer leaves that transfer counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (cnt_clr) begin
            err_cnt_q <= w_xfer_err ? CNT_W'(1) : '0;
        end else if (w_xfer_err && (err_cnt_q != c_CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign w_unused = ^{s1_p_q, res_q};

endmodule
`default_nettype wire

// File: tb/tb_an_barrett_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_an_barrett_decoder_pipe
// Brief   : Scoreboard bench for four decoder configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_an_barrett_decoder_pipe;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   deliv0 = 0, deliv1 = 0, deliv2 = 0, deliv3 = 0;
    exp_t sb0[$], sb1[$], sb2[$], sb3[$];

    logic       cnt_clr0 = 1'b0, cnt_clr1 = 1'b0, cnt_clr2 = 1'b0, cnt_clr3 = 1'b0;
    logic [7:0] err_cnt0, err_cnt2, err_cnt3;
    logic [1:0] err_cnt1;

    always #5 clk = ~clk;

    an_barrett_decoder_pipe_if #(.W(6),  .A(13)) bus0 ();
    an_barrett_decoder_pipe_if #(.W(6),  .A(13)) bus1 ();
    an_barrett_decoder_pipe_if #(.W(8),  .A(3))  bus2 ();
    an_barrett_decoder_pipe_if #(.W(10), .A(29)) bus3 ();

    an_barrett_decoder_pipe #(.W(6),  .A(13), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .cnt_clr(cnt_clr0), .err_cnt(err_cnt0));
    an_barrett_decoder_pipe #(.W(6),  .A(13), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .cnt_clr(cnt_clr1), .err_cnt(err_cnt1));
    an_barrett_decoder_pipe #(.W(8),  .A(3),  .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .cnt_clr(cnt_clr2), .err_cnt(err_cnt2));
    an_barrett_decoder_pipe #(.W(10), .A(29), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .cnt_clr(cnt_clr3), .err_cnt(err_cnt3));

    function automatic exp_t model(input int x, input int a);
        exp_t e;
        e.q = 32'(x / a);
        e.r = 32'(x % a);
        e.e = ((x % a) != 0);
        return e;
    endfunction

    // Push on every accepted input, pop and compare on every delivered result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus0.in_valid && bus0.in_ready) sb0.push_back(model(int'(bus0.in_word), 13));
            if (bus1.in_valid && bus1.in_ready) sb1.push_back(model(int'(bus1.in_word), 13));
            if (bus2.in_valid && bus2.in_ready) sb2.push_back(model(int'(bus2.in_word), 3));
            if (bus3.in_valid && bus3.in_ready) sb3.push_back(model(int'(bus3.in_word), 29));
            if (bus0.out_valid && bus0.out_ready) begin
                checks++;
                if (sb0.size() == 0) begin
                    errors++; $display("FAIL out0_unexpected q=%0d r=%0d", bus0.out_q, bus0.out_r);
                end else begin
                    e = sb0.pop_front(); deliv0++;
                    if (32'(bus0.out_q) !== e.q || 32'(bus0.out_r) !== e.r || bus0.out_err !== e.e) begin
                        errors++;
                        $display("FAIL out0 got q=%0d r=%0d err=%0b want q=%0d r=%0d err=%0b",
                                 bus0.out_q, bus0.out_r, bus0.out_err, e.q, e.r, e.e);
                    end
                end
            end
            if (bus1.out_valid && bus1.out_ready) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++; $display("FAIL out1_unexpected q=%0d r=%0d", bus1.out_q, bus1.out_r);
                end else begin
                    e = sb1.pop_front(); deliv1++;
                    if (32'(bus1.out_q) !== e.q || 32'(bus1.out_r) !== e.r || bus1.out_err !== e.e) begin
                        errors++;
                        $display("FAIL out1 got q=%0d r=%0d err=%0b want q=%0d r=%0d err=%0b",
                                 bus1.out_q, bus1.out_r, bus1.out_err, e.q, e.r, e.e);
                    end
                end
            end
            if (bus2.out_valid && bus2.out_ready) begin
                checks++;
                if (sb2.size() == 0) begin
                    errors++; $display("FAIL out2_unexpected q=%0d r=%0d", bus2.out_q, bus2.out_r);
                end else begin
                    e = sb2.pop_front(); deliv2++;
                    if (32'(bus2.out_q) !== e.q || 32'(bus2.out_r) !== e.r || bus2.out_err !== e.e) begin
                        errors++;
                        $display("FAIL out2 got q=%0d r=%0d err=%0b want q=%0d r=%0d err=%0b",
                                 bus2.out_q, bus2.out_r, bus2.out_err, e.q, e.r, e.e);
                    end
                end
            end
            if (bus3.out_valid && bus3.out_ready) begin
                checks++;
                if (sb3.size() == 0) begin
                    errors++; $display("FAIL out3_unexpected q=%0d r=%0d", bus3.out_q, bus3.out_r);
                end else begin
                    e = sb3.pop_front(); deliv3++;
                    if (32'(bus3.out_q) !== e.q || 32'(bus3.out_r) !== e.r || bus3.out_err !== e.e) begin
                        errors++;
                        $display("FAIL out3 got q=%0d r=%0d err=%0b want q=%0d r=%0d err=%0b",
                                 bus3.out_q, bus3.out_r, bus3.out_err, e.q, e.r, e.e);
                    end
                end
            end
        end
    end

    task automatic send0(input int x);
        bit ok;
        ok = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_word  = 6'(x);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = bus0.in_ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send0_timeout word=%0d in_ready=%0b want 1", x, bus0.in_ready);
        end
    endtask

    task automatic send1(input int x);
        bus1.in_valid = 1'b1;
        bus1.in_word  = 6'(x);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int n);
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        bus3.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 7;
        if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", bus0.out_valid); end
        if (bus0.out_q !== 3'd0)     begin errors++; $display("FAIL rst_out_q got %0d want 0", bus0.out_q); end
        if (bus0.out_r !== 4'd0)     begin errors++; $display("FAIL rst_out_r got %0d want 0", bus0.out_r); end
        if (bus0.out_err !== 1'b0)   begin errors++; $display("FAIL rst_out_err got %0b want 0", bus0.out_err); end
        if (err_cnt0 !== 8'd0)       begin errors++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt0); end
        if (bus0.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %0b want 1", bus0.in_ready); end
        if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid3 got %0b want 0", bus3.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream_valid;
        int lat;
        send0(13); send0(26); send0(39); send0(52);
        drain(6);
        checks += 2;
        if (deliv0 !== 4)      begin errors++; $display("FAIL valid_deliv got %0d want 4", deliv0); end
        if (err_cnt0 !== 8'd0) begin errors++; $display("FAIL valid_err_cnt got %0d want 0", err_cnt0); end
        send0(26);
        bus0.in_valid = 1'b0;
        lat = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus0.out_valid) break;
            lat++;
        end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL latency got %0d want 3", lat); end
        drain(4);
    endtask

    task automatic test_err_stream;
        int base;
        base = deliv0;
        send0(1); send0(12); send0(27); send0(38); send0(53); send0(63);
        drain(6);
        checks += 2;
        if (deliv0 - base !== 6) begin errors++; $display("FAIL errs_deliv got %0d want 6", deliv0 - base); end
        if (err_cnt0 !== 8'd6)   begin errors++; $display("FAIL errs_err_cnt got %0d want 6", err_cnt0); end
    endtask

    task automatic test_backpressure;
        int   base;
        exp_t f;
        base = deliv0;
        send0(5); send0(20); send0(27);
        bus0.in_word   = 6'd40;
        bus0.out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            f = (sb0.size() != 0) ? sb0[0] : '0;
            checks += 2;
            if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hs got in_ready=%0b out_valid=%0b want 0/1", bus0.in_ready, bus0.out_valid);
            end
            if (32'(bus0.out_q) !== f.q || 32'(bus0.out_r) !== f.r || bus0.out_err !== f.e) begin
                errors++;
                $display("FAIL stall_hold got q=%0d r=%0d want q=%0d r=%0d", bus0.out_q, bus0.out_r, f.q, f.r);
            end
        end
        @(posedge clk); #1;
        bus0.out_ready = 1'b1;
        send0(40);
        drain(6);
        checks += 3;
        if (deliv0 - base !== 4) begin errors++; $display("FAIL bp_deliv got %0d want 4", deliv0 - base); end
        if (sb0.size() !== 0)    begin errors++; $display("FAIL bp_leftover got %0d want 0", sb0.size()); end
        if (err_cnt0 !== 8'd10)  begin errors++; $display("FAIL bp_err_cnt got %0d want 10", err_cnt0); end
    endtask

    task automatic test_counter;
        bit seen;
        for (int x = 1; x <= 5; x++) send1(x);
        drain(6);
        checks++;
        if (err_cnt1 !== 2'd3) begin errors++; $display("FAIL cnt_sat got %0d want 3", err_cnt1); end
        send1(7);
        bus1.in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = bus1.out_valid;
        end
        cnt_clr1 = 1'b1;
        @(posedge clk); #1;
        cnt_clr1 = 1'b0;
        checks++;
        if (!seen || err_cnt1 !== 2'd1) begin
            errors++; $display("FAIL cnt_clr_xfer got %0d want 1 (seen=%0b)", err_cnt1, seen);
        end
        @(posedge clk); #1;
        cnt_clr1 = 1'b1;
        @(posedge clk); #1;
        cnt_clr1 = 1'b0;
        checks++;
        if (err_cnt1 !== 2'd0) begin errors++; $display("FAIL cnt_clr_only got %0d want 0", err_cnt1); end
    endtask

    task automatic test_reset_midstream;
        int base;
        send0(1); send0(2); send0(3);
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        #1;
        checks += 2;
        if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got %0b want 0", bus0.out_valid); end
        if (err_cnt0 !== 8'd0)       begin errors++; $display("FAIL mrst_err_cnt got %0d want 0", err_cnt0); end
        sb0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        base = deliv0;
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready got %0b want 1", bus0.in_ready); end
        drain(6);
        checks++;
        if (deliv0 !== base) begin errors++; $display("FAIL mrst_dropped got %0d want %0d", deliv0, base); end
    endtask

    task automatic test_sweep;
        int b0;
        b0 = deliv0;
        for (int x = 0; x < 1024; x++) begin
            bus0.in_valid = (x < 64);
            bus0.in_word  = 6'(x);
            bus2.in_valid = (x < 256);
            bus2.in_word  = 8'(x);
            bus3.in_valid = 1'b1;
            bus3.in_word  = 10'(x);
            @(posedge clk); #1;
        end
        drain(8);
        checks += 6;
        if (deliv0 - b0 !== 64) begin errors++; $display("FAIL sweep0_deliv got %0d want 64", deliv0 - b0); end
        if (deliv2 !== 256)     begin errors++; $display("FAIL sweep2_deliv got %0d want 256", deliv2); end
        if (deliv3 !== 1024)    begin errors++; $display("FAIL sweep3_deliv got %0d want 1024", deliv3); end
        if (err_cnt0 !== 8'd59) begin errors++; $display("FAIL sweep0_err_cnt got %0d want 59", err_cnt0); end
        if (err_cnt2 !== 8'd170) begin errors++; $display("FAIL sweep2_err_cnt got %0d want 170", err_cnt2); end
        if (err_cnt3 !== 8'd255) begin errors++; $display("FAIL sweep3_err_cnt got %0d want 255", err_cnt3); end
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.in_word = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_word = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_word = '0; bus2.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_word = '0; bus3.out_ready = 1'b1;
        test_reset();
        test_stream_valid();
        test_err_stream();
        test_backpressure();
        test_counter();
        test_reset_midstream();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
